// File: rtl/add3_share_arbiter_if.sv
// Request/response bundle between three sum consumers and the shared three-operand adder.
// Operands of requester i sit at bits [i*W +: W] of each op_* vector.
interface add3_share_arbiter_if #(
    parameter int W     = 5,
    parameter int CNT_W = 8
);
    logic [2:0]       req;
    logic [3*W-1:0]   op_x;
    logic [3*W-1:0]   op_y;
    logic [3*W-1:0]   op_a;
    logic [2:0]       ack;
    logic [W-1:0]     result;
    logic             ovf;
    logic [1:0]       gnt_id;
    logic             busy;
    logic [CNT_W-1:0] done_cnt;

    modport master (
        output req, op_x, op_y, op_a,
        input  ack, result, ovf, gnt_id, busy, done_cnt
    );

    modport slave (
        input  req, op_x, op_y, op_a,
        output ack, result, ovf, gnt_id, busy, done_cnt
    );
endinterface

// File: rtl/add3_share_arbiter.sv
// One registered x+y+a adder shared round-robin by three requesters, one transaction
// in flight (IDLE -> CALC -> RESP), with a wrapping completed-transaction counter.
module add3_share_arbiter #(
    parameter int W     = 5,
    parameter int SAT   = 0,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    add3_share_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_last;
    logic [1:0]       r_gnt;
    logic [W-1:0]     r_x;
    logic [W-1:0]     r_y;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_result;
    logic             r_ovf;
    logic             r_busy;
    logic [2:0]       r_ack;
    logic [CNT_W-1:0] r_done_cnt;

    logic             w_any;
    logic [1:0]       w_win;
    logic [W+1:0]     w_sum;
    logic [W-1:0]     w_res;
    logic             w_ovf;
    logic [2:0]       w_ack_d;
    logic             w_busy_d;
    logic             w_grant;
    logic             w_calc;
    logic             w_count;

    // Scan order starts just after the last winner, so a just-served requester ranks last.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        case (last)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (req[first]) begin
            rr_pick = first;
        end else if (req[second]) begin
            rr_pick = second;
        end else begin
            rr_pick = third;
        end
    endfunction

    assign w_any = |bus.req;
    assign w_win = rr_pick(bus.req, r_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: only IDLE waits on a request
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC:  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: next-cycle values for the registered outputs plus datapath enables
    always_comb begin
        w_ack_d  = 3'b000;
        w_busy_d = 1'b0;
        w_grant  = 1'b0;
        w_calc   = 1'b0;
        w_count  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant  = w_any;
                w_busy_d = w_any;
            end
            S_CALC: begin
                w_calc   = 1'b1;
                w_ack_d  = 3'b001 << r_gnt;
                w_busy_d = 1'b1;
            end
            S_RESP: begin
                w_count  = 1'b1;
            end
            default: begin
                w_ack_d  = 3'b000;
                w_busy_d = 1'b0;
            end
        endcase
    end

    // Sum at W+2 bits so the carry of three W-bit operands is never lost
    always_comb begin
        w_sum = {2'b00, r_x} + {2'b00, r_y} + {2'b00, r_a};
        w_ovf = (w_sum[W+1:W] != 2'b00);
        if ((SAT != 0) && w_ovf) begin
            w_res = {W{1'b1}};
        end else begin
            w_res = w_sum[W-1:0];
        end
    end

    // Datapath and output registers; result/ovf hold until the next CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 2'd2;
            r_gnt      <= 2'd0;
            r_x        <= {W{1'b0}};
            r_y        <= {W{1'b0}};
            r_a        <= {W{1'b0}};
            r_result   <= {W{1'b0}};
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_ack      <= 3'b000;
            r_done_cnt <= {CNT_W{1'b0}};
        end else begin
            r_ack  <= w_ack_d;
            r_busy <= w_busy_d;
            if (w_grant) begin
                r_gnt  <= w_win;
                r_last <= w_win;
                r_x    <= bus.op_x[int'(w_win)*W +: W];
                r_y    <= bus.op_y[int'(w_win)*W +: W];
                r_a    <= bus.op_a[int'(w_win)*W +: W];
            end
            if (w_calc) begin
                r_result <= w_res;
                r_ovf    <= w_ovf;
            end
            if (w_count) begin
                r_done_cnt <= r_done_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ack      = r_ack;
    assign bus.result   = r_result;
    assign bus.ovf      = r_ovf;
    assign bus.gnt_id   = r_gnt;
    assign bus.busy     = r_busy;
    assign bus.done_cnt = r_done_cnt;
endmodule

// File: tb/tb_add3_share_arbiter.sv
// Scoreboard bench: dut0 wraps (SAT=0, CNT_W=8), dut1 saturates with a 2-bit counter.
module tb_add3_share_arbiter;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add3_share_arbiter_if #(.W(W), .CNT_W(8)) m0 ();
    add3_share_arbiter_if #(.W(W), .CNT_W(2)) m1 ();

    add3_share_arbiter #(.W(W), .SAT(0), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(m0));
    add3_share_arbiter #(.W(W), .SAT(1), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));

    int n_cmp = 0;
    int n_err = 0;

    // Entries are {ack, result, ovf}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] mon0_exp;
    logic [8:0] mon1_exp;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] a, input bit sat);
        int s;
        logic [W-1:0] r;
        logic o;
        s = int'(x) + int'(y) + int'(a);
        o = (s >= (1 << W));
        if (sat && o) r = {W{1'b1}};
        else          r = s[W-1:0];
        return {o, r};
    endfunction

    function automatic logic [8:0] entry(input int id, input logic [W:0] ro);
        logic [2:0] oh;
        oh = 3'b001 << id;
        return {oh, ro[W-1:0], ro[W]};
    endfunction

    // Scoreboard for dut0: every ack must match the oldest pending expectation
    always @(negedge clk) begin
        if (m0.ack !== 3'b000) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL sb0_unexpected_ack actual ack=%b required none", m0.ack);
            end else begin
                mon0_exp = q0.pop_front();
                if ({m0.ack, m0.result, m0.ovf} !== mon0_exp) begin
                    n_err++;
                    $display("FAIL sb0 actual ack=%b res=%0d ovf=%b required ack=%b res=%0d ovf=%b",
                             m0.ack, m0.result, m0.ovf, mon0_exp[8:6], mon0_exp[5:1], mon0_exp[0]);
                end
            end
        end
    end

    // Scoreboard for dut1
    always @(negedge clk) begin
        if (m1.ack !== 3'b000) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL sb1_unexpected_ack actual ack=%b required none", m1.ack);
            end else begin
                mon1_exp = q1.pop_front();
                if ({m1.ack, m1.result, m1.ovf} !== mon1_exp) begin
                    n_err++;
                    $display("FAIL sb1 actual ack=%b res=%0d ovf=%b required ack=%b res=%0d ovf=%b",
                             m1.ack, m1.result, m1.ovf, mon1_exp[8:6], mon1_exp[5:1], mon1_exp[0]);
                end
            end
        end
    end

    task automatic set_ops(input int d, input int id, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] a);
        if (d == 0) begin
            m0.op_x[id*W +: W] = x; m0.op_y[id*W +: W] = y; m0.op_a[id*W +: W] = a;
        end else begin
            m1.op_x[id*W +: W] = x; m1.op_y[id*W +: W] = y; m1.op_a[id*W +: W] = a;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m0.req = 3'b000;
        m1.req = 3'b000;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated transaction on dut d from requester id; checks latency and gnt_id
    task automatic single_txn(input int d, input int id, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] a);
        int lat;
        bit got;
        logic [2:0] ack;
        @(negedge clk);
        set_ops(d, id, x, y, a);
        if (d == 0) begin q0.push_back(entry(id, ref_add(x, y, a, 1'b0))); m0.req[id] = 1'b1; end
        else        begin q1.push_back(entry(id, ref_add(x, y, a, 1'b1))); m1.req[id] = 1'b1; end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            ack = (d == 0) ? m0.ack : m1.ack;
            if (ack[id]) got = 1'b1;
        end
        if (d == 0) m0.req[id] = 1'b0;
        else        m1.req[id] = 1'b0;
        n_cmp++;
        if (!got || lat != 2) begin
            n_err++;
            $display("FAIL txn_latency dut%0d req%0d actual %0d cycles (got=%0d) required 2", d, id, lat, got);
        end
        n_cmp++;
        if (((d == 0) ? m0.gnt_id : m1.gnt_id) !== 2'(id)) begin
            n_err++;
            $display("FAIL txn_gnt_id dut%0d actual %0d required %0d", d,
                     (d == 0) ? m0.gnt_id : m1.gnt_id, id);
        end
    endtask

    task automatic test_reset();
        m0.req = 3'b000; m0.op_x = '0; m0.op_y = '0; m0.op_a = '0;
        m1.req = 3'b000; m1.op_x = '0; m1.op_y = '0; m1.op_a = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m0.ack, m0.result, m0.ovf, m0.busy, m0.gnt_id, m0.done_cnt} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_dut0 actual ack=%b res=%0d ovf=%b busy=%b gnt=%0d cnt=%0d required all 0",
                     m0.ack, m0.result, m0.ovf, m0.busy, m0.gnt_id, m0.done_cnt);
        end
        n_cmp++;
        if ({m1.ack, m1.result, m1.ovf, m1.busy, m1.gnt_id, m1.done_cnt} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_dut1 actual ack=%b res=%0d busy=%b cnt=%0d required all 0",
                     m1.ack, m1.result, m1.busy, m1.done_cnt);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        set_ops(0, 0, 5'd1, 5'd2, 5'd3);
        q0.push_back({3'b001, 5'd6, 1'b0});
        m0.req = 3'b001;
        @(negedge clk);
        n_cmp++;
        if (m0.busy !== 1'b1 || m0.ack !== 3'b000) begin
            n_err++;
            $display("FAIL basic_calc actual busy=%b ack=%b required busy=1 ack=000", m0.busy, m0.ack);
        end
        m0.op_x[0 +: W] = 5'd31;
        @(negedge clk);
        n_cmp++;
        if (m0.ack !== 3'b001) begin
            n_err++;
            $display("FAIL basic_ack_time actual ack=%b required 001", m0.ack);
        end
        m0.req = 3'b000;
        @(negedge clk);
        n_cmp++;
        if (m0.done_cnt !== 8'd1 || m0.busy !== 1'b0 || m0.result !== 5'd6 || m0.ack !== 3'b000) begin
            n_err++;
            $display("FAIL basic_after actual cnt=%0d busy=%b res=%0d ack=%b required cnt=1 busy=0 res=6 ack=000",
                     m0.done_cnt, m0.busy, m0.result, m0.ack);
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        set_ops(0, 1, 5'd20, 5'd10, 5'd5);
        set_ops(1, 1, 5'd20, 5'd10, 5'd5);
        q0.push_back({3'b010, 5'd3, 1'b1});
        q1.push_back({3'b010, 5'd31, 1'b1});
        m0.req = 3'b010;
        m1.req = 3'b010;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m0.ack !== 3'b010 || m1.ack !== 3'b010) begin
            n_err++;
            $display("FAIL ovf_ack actual ack0=%b ack1=%b required 010/010", m0.ack, m1.ack);
        end
        m0.req = 3'b000;
        m1.req = 3'b000;
        @(negedge clk);
        n_cmp++;
        if (m0.result !== 5'd3 || m0.ovf !== 1'b1 || m1.result !== 5'd31 || m1.ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_hold actual res0=%0d ovf0=%b res1=%0d ovf1=%b required 3/1 31/1",
                     m0.result, m0.ovf, m1.result, m1.ovf);
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] px[6];
        logic [W-1:0] py[6];
        logic [W-1:0] pa[6];
        px = '{5'd31, 5'd10, 5'd31, 5'd0, 5'd0, 5'd17};
        py = '{5'd0,  5'd10, 5'd31, 5'd0, 5'd31, 5'd8};
        pa = '{5'd1,  5'd11, 5'd31, 5'd0, 5'd0, 5'd7};
        for (int k = 0; k < 6; k++) begin
            single_txn(0, k % 3, px[k], py[k], pa[k]);
            single_txn(1, (k + 1) % 3, px[k], py[k], pa[k]);
        end
        for (int k = 0; k < 4; k++) begin
            single_txn(k % 2, k % 3, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)));
        end
    endtask

    task automatic test_round_robin();
        int t_ack[3];
        int want[3];
        pulse_reset();
        want = '{2, 5, 8};
        for (int i = 0; i < 3; i++) begin
            t_ack[i] = -1;
            set_ops(0, i, 5'(i + 1), 5'(2 * i), 5'd7);
            q0.push_back(entry(i, ref_add(5'(i + 1), 5'(2 * i), 5'd7, 1'b0)));
        end
        m0.req = 3'b111;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (m0.ack[i] === 1'b1) begin
                    t_ack[i] = n;
                    m0.req[i] = 1'b0;
                end
            end
            if (t_ack[2] >= 0) break;
        end
        m0.req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (t_ack[i] != want[i]) begin
                n_err++;
                $display("FAIL rr_ack_cycle req%0d actual %0d required %0d", i, t_ack[i], want[i]);
            end
        end
    endtask

    task automatic test_fairness();
        int order[4];
        int want[4];
        int k;
        want = '{0, 1, 0, 1};
        order = '{-1, -1, -1, -1};
        @(negedge clk);
        set_ops(0, 0, 5'd9, 5'd4, 5'd2);
        set_ops(0, 1, 5'd30, 5'd1, 5'd1);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(entry(want[i], ref_add((want[i] == 0) ? 5'd9 : 5'd30,
                                                (want[i] == 0) ? 5'd4 : 5'd1,
                                                (want[i] == 0) ? 5'd2 : 5'd1, 1'b0)));
        end
        m0.req = 3'b011;
        k = 0;
        for (int n = 0; n < 20 && k < 4; n++) begin
            @(negedge clk);
            if (m0.ack[0] === 1'b1) begin order[k] = 0; k++; end
            else if (m0.ack[1] === 1'b1) begin order[k] = 1; k++; end
        end
        m0.req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (order[i] != want[i]) begin
                n_err++;
                $display("FAIL fair_order slot%0d actual %0d required %0d", i, order[i], want[i]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_in_calc();
        int first;
        int seen;
        @(negedge clk);
        set_ops(0, 0, 5'd3, 5'd4, 5'd5);
        m0.req = 3'b001;
        @(negedge clk);
        n_cmp++;
        if (m0.busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_calc_busy actual %b required 1", m0.busy);
        end
        rst_n = 1'b0;
        m0.req = 3'b000;
        #1;
        n_cmp++;
        if (m0.ack !== 3'b000 || m0.result !== 5'd0 || m0.busy !== 1'b0 || m0.done_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL rst_calc_clear actual ack=%b res=%0d busy=%b cnt=%0d required 000/0/0/0",
                     m0.ack, m0.result, m0.busy, m0.done_cnt);
        end
        @(negedge clk);
        n_cmp++;
        if (m0.ack !== 3'b000) begin
            n_err++;
            $display("FAIL rst_calc_no_ack actual %b required 000", m0.ack);
        end
        rst_n = 1'b1;
        set_ops(0, 1, 5'd1, 5'd1, 5'd1);
        q0.push_back(entry(0, ref_add(5'd3, 5'd4, 5'd5, 1'b0)));
        q0.push_back(entry(1, ref_add(5'd1, 5'd1, 5'd1, 1'b0)));
        m0.req = 3'b011;
        first = -1;
        seen = 0;
        for (int n = 0; n < 15 && seen < 2; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (m0.ack[i] === 1'b1) begin
                    if (first < 0) first = i;
                    seen++;
                    m0.req[i] = 1'b0;
                end
            end
        end
        m0.req = 3'b000;
        n_cmp++;
        if (first != 0) begin
            n_err++;
            $display("FAIL rst_calc_first_grant actual %0d required 0", first);
        end
    endtask

    task automatic test_cnt_wrap();
        int want[5];
        want = '{1, 2, 3, 0, 1};
        for (int k = 0; k < 5; k++) begin
            single_txn(1, 2, 5'(k), 5'd3, 5'd9);
            @(negedge clk);
            n_cmp++;
            if (m1.done_cnt !== 2'(want[k])) begin
                n_err++;
                $display("FAIL cnt_wrap step%0d actual %0d required %0d", k, m1.done_cnt, want[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_patterns();
        test_round_robin();
        test_fairness();
        test_reset_in_calc();
        test_cnt_wrap();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain actual pending %0d/%0d required 0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
